// File: rtl/switch_debounce.sv
// Switch debouncer: synchronizer, stability-counter filter, registered press/release strobes.
// Optional macro SWITCH_DEBOUNCE_RELEASE_COUNT_EN adds an 8-bit wrapping release counter port.
module switch_debounce #(
    parameter int unsigned DEBOUNCE_LIMIT = 250000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Switch,
    output logic       o_Switch,
    output logic       o_Press_Pulse,
    output logic       o_Release_Pulse
`ifdef SWITCH_DEBOUNCE_RELEASE_COUNT_EN
    ,
    output logic [7:0] o_Release_Count
`endif
);

    localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        ST_STABLE,
        ST_COUNT
    } state_t;

    logic [SYNC_STAGES-1:0] r_Sync;
    logic                   w_Sync;

    state_t                 r_State;
    state_t                 w_State_Next;
    logic [CNT_W-1:0]       r_Count;
    logic [CNT_W-1:0]       w_Count_Next;
    logic                   w_Switch_Next;
    logic                   w_Press_Next;
    logic                   w_Release_Next;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Sync <= '0;
        end else begin
            r_Sync <= {r_Sync[SYNC_STAGES-2:0], i_Switch};
        end
    end

    assign w_Sync = r_Sync[SYNC_STAGES-1];

    // Any return of w_Sync to the accepted level drops back to ST_STABLE, restarting the count.
    always_comb begin
        w_State_Next   = r_State;
        w_Count_Next   = '0;
        w_Switch_Next  = o_Switch;
        w_Press_Next   = 1'b0;
        w_Release_Next = 1'b0;
        unique case (r_State)
            ST_STABLE: begin
                if (w_Sync != o_Switch) begin
                    w_State_Next = ST_COUNT;
                    w_Count_Next = CNT_ONE;
                end
            end
            ST_COUNT: begin
                if (w_Sync == o_Switch) begin
                    w_State_Next = ST_STABLE;
                end else if (r_Count == CNT_MAX) begin
                    w_State_Next   = ST_STABLE;
                    w_Switch_Next  = w_Sync;
                    w_Press_Next   = w_Sync;
                    w_Release_Next = ~w_Sync;
                end else begin
                    w_Count_Next = r_Count + 1'b1;
                end
            end
            default: begin
                w_State_Next = ST_STABLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State         <= ST_STABLE;
            r_Count         <= '0;
            o_Switch        <= 1'b0;
            o_Press_Pulse   <= 1'b0;
            o_Release_Pulse <= 1'b0;
        end else begin
            r_State         <= w_State_Next;
            r_Count         <= w_Count_Next;
            o_Switch        <= w_Switch_Next;
            o_Press_Pulse   <= w_Press_Next;
            o_Release_Pulse <= w_Release_Next;
        end
    end

`ifdef SWITCH_DEBOUNCE_RELEASE_COUNT_EN
    logic [7:0] r_Release_Count;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Release_Count <= '0;
        end else if (o_Release_Pulse) begin
            r_Release_Count <= r_Release_Count + 8'd1;
        end
    end

    assign o_Release_Count = r_Release_Count;
`endif

endmodule
